// File: rtl/skeleton_capture_pkg.sv
// Shared types and elaboration helpers for the skeleton ROM capture block.
package skeleton_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_CAPTURE,
        ST_DRAIN,
        ST_SEND
    } state_t;

    // Frame layout after the header beats: count beat, then the samples.
    localparam int COUNT_BEAT_OFFSET   = 0;
    localparam int FIRST_SAMPLE_OFFSET = 1;

    function automatic int clog2(input int value);
        int result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int head_beats(input int head_width, input int word_width);
        return (head_width + word_width - 1) / word_width;
    endfunction

endpackage

// File: rtl/capture_buf.sv
// Capture buffer: one write port, one registered read port (1-cycle read latency).
module capture_buf
    import skeleton_capture_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16
) (
    input  logic                     CLK_SYS,
    input  logic                     WE,
    input  logic [clog2(DEPTH)-1:0]  WADDR,
    input  logic [WIDTH-1:0]         WDATA,
    input  logic [clog2(DEPTH)-1:0]  RADDR,
    output logic [WIDTH-1:0]         RDATA
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK_SYS) begin
        if (WE) begin
            mem[WADDR] <= WDATA;
        end
        RDATA <= mem[RADDR];
    end

endmodule

// File: rtl/skeleton_rom_capture.sv
// Host-side driver for the ROM test skeleton: arm, capture until RDY, stream a frame.
// Optional capture abort timer enabled by defining CAPTURE_TIMEOUT_EN.
module skeleton_rom_capture
    import skeleton_capture_pkg::*;
#(
    parameter int                      BITWIDTH_SYS   = 16,
    parameter int                      BITWIDTH_HEAD  = 26,
    parameter int                      DEPTH          = 64,
    parameter logic [BITWIDTH_SYS-1:0] STIM_VALUE     = 16'h0001,
    parameter int                      TIMEOUT_CYCLES = 4096
) (
    input  logic                     CLK_SYS,
    input  logic                     RST,
    input  logic                     START,
    output logic                     BUSY,
    output logic                     OVERFLOW,
    output logic                     TIMEOUT,
    output logic                     DUT_EN,
    output logic                     DUT_TRGG,
    output logic [BITWIDTH_SYS-1:0]  DUT_DATA_IN,
    input  logic [BITWIDTH_SYS-1:0]  DUT_DATA_OUT,
    input  logic [BITWIDTH_HEAD-1:0] DUT_HEAD,
    input  logic                     DUT_RDY,
    output logic [BITWIDTH_SYS-1:0]  OUT_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY
);

    localparam int HEAD_BEATS   = head_beats(BITWIDTH_HEAD, BITWIDTH_SYS);
    localparam int HEAD_EXT_W   = HEAD_BEATS * BITWIDTH_SYS;
    localparam int AW           = clog2(DEPTH);
    localparam int CW           = AW + 1;
    localparam int COUNT_BEAT   = HEAD_BEATS + COUNT_BEAT_OFFSET;
    localparam int FIRST_SAMPLE = HEAD_BEATS + FIRST_SAMPLE_OFFSET;
    localparam int BEAT_W       = clog2(FIRST_SAMPLE + DEPTH) + 1;

    state_t                   state;
    state_t                   next_state;
    logic [CW-1:0]            count;
    logic                     overflow_q;
    logic [BITWIDTH_HEAD-1:0] head_q;
    logic [HEAD_EXT_W-1:0]    head_ext;
    logic [BEAT_W-1:0]        beat;
    logic [BEAT_W-1:0]        beat_nxt;
    logic [BEAT_W-1:0]        last_beat;
    logic [AW-1:0]            raddr;
    logic [BITWIDTH_SYS-1:0]  rdata;
    logic                     we;
    logic                     fire;
    logic                     start_ok;
    logic                     timeout_hit;

    assign start_ok  = (state == ST_IDLE) && START;
    assign we        = (state == ST_CAPTURE) && (count < CW'(DEPTH));
    assign fire      = (state == ST_SEND) && OUT_READY;
    assign head_ext  = HEAD_EXT_W'(head_q);
    assign last_beat = BEAT_W'(FIRST_SAMPLE) + BEAT_W'(count) - BEAT_W'(1);
    assign beat_nxt  = fire ? beat + BEAT_W'(1) : beat;
    assign OVERFLOW  = overflow_q;

    // Address the sample the next beat will need so a stalled beat keeps its data
    // and a transferring beat has its successor ready one cycle later.
    assign raddr = (beat_nxt >= BEAT_W'(FIRST_SAMPLE))
                 ? AW'(beat_nxt - BEAT_W'(FIRST_SAMPLE)) : '0;

    capture_buf #(
        .DEPTH (DEPTH),
        .WIDTH (BITWIDTH_SYS)
    ) u_buf (
        .CLK_SYS (CLK_SYS),
        .WE      (we),
        .WADDR   (count[AW-1:0]),
        .WDATA   (DUT_DATA_OUT),
        .RADDR   (raddr),
        .RDATA   (rdata)
    );

    always_ff @(posedge CLK_SYS or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        BUSY        = 1'b1;
        DUT_EN      = 1'b0;
        DUT_TRGG    = 1'b0;
        DUT_DATA_IN = '0;
        OUT_VALID   = 1'b0;
        case (state)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (START) next_state = ST_ARM;
            end
            ST_ARM: begin
                DUT_EN      = 1'b1;
                DUT_TRGG    = 1'b1;
                DUT_DATA_IN = STIM_VALUE;
                next_state  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                DUT_EN      = 1'b1;
                DUT_DATA_IN = STIM_VALUE;
                if (DUT_RDY || timeout_hit) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                next_state = ST_SEND;
            end
            ST_SEND: begin
                OUT_VALID = 1'b1;
                if (OUT_READY && (beat == last_beat)) next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_SYS or posedge RST) begin
        if (RST) begin
            count      <= '0;
            overflow_q <= 1'b0;
            head_q     <= '0;
            beat       <= '0;
        end else begin
            if (start_ok) begin
                count      <= '0;
                overflow_q <= 1'b0;
                head_q     <= DUT_HEAD;
                beat       <= '0;
            end else begin
                if (we) begin
                    count <= count + CW'(1);
                    if ((count == CW'(DEPTH - 1)) && !DUT_RDY) overflow_q <= 1'b1;
                end
                if (fire) beat <= beat + BEAT_W'(1);
            end
        end
    end

    // Header beats go out MSB-first from the zero-extended header.
    always_comb begin
        OUT_DATA = '0;
        if (state == ST_SEND) begin
            if (beat == BEAT_W'(COUNT_BEAT)) begin
                OUT_DATA = BITWIDTH_SYS'(count);
            end else if (beat > BEAT_W'(COUNT_BEAT)) begin
                OUT_DATA = rdata;
            end else begin
                for (int i = 0; i < HEAD_BEATS; i++) begin
                    if (beat == BEAT_W'(i)) begin
                        OUT_DATA = head_ext[(HEAD_BEATS-1-i)*BITWIDTH_SYS +: BITWIDTH_SYS];
                    end
                end
            end
        end
    end

`ifdef CAPTURE_TIMEOUT_EN
    localparam int TCW = clog2(TIMEOUT_CYCLES) + 1;

    logic [TCW-1:0] tcnt;
    logic           timeout_q;

    assign timeout_hit = (state == ST_CAPTURE) && !DUT_RDY
                       && (tcnt == TCW'(TIMEOUT_CYCLES - 1));
    assign TIMEOUT     = timeout_q;

    always_ff @(posedge CLK_SYS or posedge RST) begin
        if (RST) begin
            tcnt      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (start_ok) timeout_q <= 1'b0;
            else if (timeout_hit) timeout_q <= 1'b1;
            if (state == ST_ARM) tcnt <= '0;
            else if (state == ST_CAPTURE) tcnt <= tcnt + TCW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
    // No abort timer in this build; the limit stays referenced so both builds share one interface.
    assign TIMEOUT     = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: doc/skeleton_rom_capture.md
Name: skeleton_rom_capture

Overview:
Host-side counterpart of the on-device ROM test skeleton. On a host START pulse it arms the skeleton, applies a constant stimulus, fires the calculation trigger, and captures every DATA_OUT word into a local buffer until the skeleton's RDY. It then streams a frame to the host link over a valid/ready interface: header beats, then sample count, then samples. It sits between the skeleton and the host transport (UART/SPI bridge).

Parameters:
BITWIDTH_SYS, 16, width of skeleton data bus and host output word
BITWIDTH_HEAD, 26, width of skeleton metadata header
DEPTH, 64, capture buffer depth in words (power of two, >=4)
STIM_VALUE, 16'h0001, constant word driven on DUT_DATA_IN during a run (must be nonzero)
TIMEOUT_CYCLES, 4096, capture abort limit (used only with the optional feature)

Ports:
CLK_SYS  in  1  system clock
RST  in  1  reset, asynchronous, active-high
START  in  1  single-cycle run request from host
BUSY  out  1  high from accepted START until the last frame beat is accepted
OVERFLOW  out  1  sticky per run: RDY not seen within DEPTH samples
TIMEOUT  out  1  sticky per run: capture aborted by timeout
DUT_EN  out  1  skeleton enable
DUT_TRGG  out  1  skeleton TRGG_START_CALC
DUT_DATA_IN  out  BITWIDTH_SYS  skeleton stimulus
DUT_DATA_OUT  in  BITWIDTH_SYS  skeleton result word
DUT_HEAD  in  BITWIDTH_HEAD  skeleton metadata
DUT_RDY  in  1  skeleton end-of-sequence flag
OUT_DATA  out  BITWIDTH_SYS  frame beat to host
OUT_VALID  out  1  frame beat valid
OUT_READY  in  1  host accepts beat

Behaviour:
- Reset (async, any time, including mid-run): state IDLE; all outputs 0; write pointer, count, and flags cleared. Buffer contents are don't-care.
- States: IDLE -> ARM -> CAPTURE -> DRAIN -> SEND -> IDLE.
- IDLE: START=1 moves to ARM next cycle. BUSY rises in the same edge. Pointer, count, OVERFLOW, and TIMEOUT clear. DUT_HEAD is latched.
- START outside IDLE is ignored.
- ARM (exactly 1 cycle): DUT_EN=1, DUT_DATA_IN=STIM_VALUE, DUT_TRGG=1. Moves to CAPTURE.
- CAPTURE: DUT_EN=1, DUT_DATA_IN=STIM_VALUE, DUT_TRGG=0.
  - Each cycle, DUT_DATA_OUT is written at the pointer and count increments, saturating at DEPTH.
  - The cycle with DUT_RDY=1 is captured as the final sample, then the state moves to DRAIN.
  - If count hits DEPTH without RDY, OVERFLOW=1, writes stop, and the block keeps waiting for RDY.
- DRAIN (1 cycle): DUT_EN=0 and DUT_DATA_IN=0, letting the buffer read pipeline prime. Moves to SEND.
- SEND frame order:
  - HEAD_BEATS = ceil(BITWIDTH_HEAD/BITWIDTH_SYS) header beats, MSB-first. The header is zero-extended on the left to HEAD_BEATS*BITWIDTH_SYS bits. With the defaults: beat0 = {6'd0, head[25:16]}, beat1 = head[15:0].
  - Then one beat of count, zero-extended.
  - Then count samples in capture order.
- Handshake: a beat transfers on OUT_VALID && OUT_READY.
  - OUT_DATA is held stable while OUT_VALID=1 and OUT_READY=0.
  - OUT_VALID never drops without a transfer.
  - Back-to-back beats are allowed (1 beat per cycle when OUT_READY is held high).
- After the last sample transfers: OUT_VALID=0, BUSY=0, state IDLE. OVERFLOW and TIMEOUT hold until the next accepted START.
- Buffer read is registered (1-cycle latency). Readout is pipelined so that 1 beat per cycle is sustained.
- count width is clog2(DEPTH)+1, so count=DEPTH is representable. The pointer wraps never.

Optional Feature:
Macro CAPTURE_TIMEOUT_EN.
- Defined: a cycle counter runs in CAPTURE. If TIMEOUT_CYCLES cycles elapse without DUT_RDY, TIMEOUT=1 and the state moves to DRAIN. The frame carries whatever was captured, up to DEPTH words.
- Not defined: no counter; CAPTURE waits for RDY indefinitely; TIMEOUT is tied 0.

Decomposition:
- Package skeleton_capture_pkg:
  - state encoding (IDLE, ARM, CAPTURE, DRAIN, SEND)
  - HEAD_BEATS function
  - clog2 helper
  - frame field order constants (beat index of count, first sample)
- Sub-module capture_buf: single-port-write / registered-read RAM, DEPTH x BITWIDTH_SYS, ports CLK_SYS, WE, WADDR, WDATA, RADDR, RDATA.

Test Plan:
- Skeleton model raises RDY on its 21st DATA_OUT word (values 0x0100..0x0114), DUT_HEAD = 26'h0C05415, OUT_READY=1 -> frame 0x00C0, 0x5415, 0x0015, 0x0100..0x0114; 24 beats; BUSY low after the last beat; OVERFLOW=0.
- Same run with OUT_READY toggling 1-0-0-1 -> identical frame; OUT_DATA stable on every stalled cycle; no beat dropped or duplicated.
- RDY only on the 70th word (DEPTH=64) -> OVERFLOW=1, count beat 0x0040, samples are words 1..64.
- CAPTURE_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, RDY never asserted -> TIMEOUT=1 at about 100 cycles after ARM; count beat 0x0040; OVERFLOW=1.
- RST asserted in CAPTURE after 10 samples, then a new START -> all outputs 0 during reset; the next frame is correct and shows no residue from the first run.
- START pulsed during SEND -> ignored; exactly one frame emitted.
